// File: rtl/rs_station_pkg.sv
// rs_station shared constants, types and helpers.
// RS_AGE_PRIORITY_EN adds per-entry age stamps for oldest-first issue.
package rs_station_pkg;
  localparam int RS_SIZE  = 16;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 6;
  localparam int IDX_W    = $clog2(RS_SIZE);
  localparam int CNT_W    = IDX_W + 1;
  localparam int AGE_W    = IDX_W + 1;

  typedef logic [ROB_ID_W-1:0] rob_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OP_W-1:0]     op_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [AGE_W-1:0]    age_t;

  localparam op_t   OPENUM_NOP = '0;
  localparam rob_t  ZERO_ROB   = '0;
  localparam data_t ZERO_WORD  = '0;

  typedef struct packed {
    logic  busy;
    op_t   op;
    data_t v1;
    data_t v2;
    rob_t  q1;
    rob_t  q2;
    data_t pc;
    data_t imm;
    rob_t  rob;
`ifdef RS_AGE_PRIORITY_EN
    age_t  age;
`endif
  } ent_t;

  typedef struct packed {
    logic  ena;
    op_t   op;
    data_t v1;
    data_t v2;
    data_t pc;
    data_t imm;
    rob_t  rob;
  } iss_t;

  localparam iss_t ISS_RST = '{
    ena: 1'b0, op: OPENUM_NOP,
    v1: ZERO_WORD, v2: ZERO_WORD,
    pc: ZERO_WORD, imm: ZERO_WORD,
    rob: ZERO_ROB
  };

  function automatic logic cdb_hit(
    input logic vld,
    input rob_t tag,
    input rob_t q
  );
    return vld && (tag != ZERO_ROB) && (tag == q);
  endfunction

`ifdef RS_AGE_PRIORITY_EN
  // Stamps come from a wrapping counter; a negative difference means older.
  function automatic logic older(input age_t a, input age_t b);
    age_t d;
    d = a - b;
    return d[AGE_W-1];
  endfunction
`endif
endpackage

// File: rtl/rs_select.sv
// Slot selection: lowest free slot, issue pick and free count.
// Under RS_AGE_PRIORITY_EN the issue pick is the oldest ready entry.
module rs_select
  import rs_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] busy_i,
  input  logic [RS_SIZE-1:0] ready_i,
`ifdef RS_AGE_PRIORITY_EN
  input  age_t               age_i [RS_SIZE],
`endif
  output logic               free_vld_o,
  output idx_t               free_idx_o,
  output logic               sel_vld_o,
  output idx_t               sel_idx_o,
  output cnt_t               free_cnt_o
);
  always_comb begin
    free_vld_o = 1'b0;
    free_idx_o = '0;
    free_cnt_o = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        free_vld_o = 1'b1;
        free_idx_o = idx_t'(i);
      end
      free_cnt_o = free_cnt_o + {{IDX_W{1'b0}}, ~busy_i[i]};
    end
  end

  always_comb begin
    sel_vld_o = 1'b0;
    sel_idx_o = '0;
`ifdef RS_AGE_PRIORITY_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_i[i] &&
          (!sel_vld_o || older(age_i[i], age_i[sel_idx_o]))) begin
        sel_vld_o = 1'b1;
        sel_idx_o = idx_t'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        sel_vld_o = 1'b1;
        sel_idx_o = idx_t'(i);
      end
    end
`endif
  end
endmodule

// File: rtl/rs_station.sv
// Reservation station for the arithmetic/branch issue port.
// RS_AGE_PRIORITY_EN selects oldest-first issue instead of lowest-index.
module rs_station
  import rs_station_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  rollback,
  input  logic  ena_from_dsp,
  input  op_t   openum_from_dsp,
  input  data_t V1_from_dsp,
  input  data_t V2_from_dsp,
  input  rob_t  Q1_from_dsp,
  input  rob_t  Q2_from_dsp,
  input  data_t pc_from_dsp,
  input  data_t imm_from_dsp,
  input  rob_t  rob_id_from_dsp,
  input  logic  valid_arith_cdb,
  input  rob_t  rob_id_arith_cdb,
  input  data_t result_arith_cdb,
  input  logic  valid_ls_cdb,
  input  rob_t  rob_id_ls_cdb,
  input  data_t result_ls_cdb,
  output logic  full_to_if,
  output logic  ena_to_alu,
  output op_t   openum_to_alu,
  output data_t V1_to_alu,
  output data_t V2_to_alu,
  output data_t pc_to_alu,
  output data_t imm_to_alu,
  output rob_t  rob_id_to_alu
);
  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];
  iss_t iss_q, iss_d;
  ent_t nw;

  logic [RS_SIZE-1:0] busy, ready;
  logic free_vld, sel_vld;
  idx_t free_idx, sel_idx;
  cnt_t free_cnt;

`ifdef RS_AGE_PRIORITY_EN
  age_t age_q, age_d;
  age_t ages [RS_SIZE];
  always_comb
    for (int i = 0; i < RS_SIZE; i++) ages[i] = ent_q[i].age;
`endif

  always_comb
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy &&
                 (ent_q[i].q1 == ZERO_ROB) &&
                 (ent_q[i].q2 == ZERO_ROB);
    end

  rs_select u_sel (
    .busy_i     (busy),
    .ready_i    (ready),
`ifdef RS_AGE_PRIORITY_EN
    .age_i      (ages),
`endif
    .free_vld_o (free_vld),
    .free_idx_o (free_idx),
    .sel_vld_o  (sel_vld),
    .sel_idx_o  (sel_idx),
    .free_cnt_o (free_cnt)
  );

  // Incoming entry with same-cycle CDB forwarding; arithmetic CDB wins.
  always_comb begin
    nw      = '0;
    nw.busy = 1'b1;
    nw.op   = openum_from_dsp;
    nw.v1   = V1_from_dsp;
    nw.v2   = V2_from_dsp;
    nw.q1   = Q1_from_dsp;
    nw.q2   = Q2_from_dsp;
    nw.pc   = pc_from_dsp;
    nw.imm  = imm_from_dsp;
    nw.rob  = rob_id_from_dsp;
`ifdef RS_AGE_PRIORITY_EN
    nw.age  = age_q;
`endif
    if (cdb_hit(valid_arith_cdb, rob_id_arith_cdb, Q1_from_dsp)) begin
      nw.v1 = result_arith_cdb;
      nw.q1 = ZERO_ROB;
    end else if (cdb_hit(valid_ls_cdb, rob_id_ls_cdb, Q1_from_dsp)) begin
      nw.v1 = result_ls_cdb;
      nw.q1 = ZERO_ROB;
    end
    if (cdb_hit(valid_arith_cdb, rob_id_arith_cdb, Q2_from_dsp)) begin
      nw.v2 = result_arith_cdb;
      nw.q2 = ZERO_ROB;
    end else if (cdb_hit(valid_ls_cdb, rob_id_ls_cdb, Q2_from_dsp)) begin
      nw.v2 = result_ls_cdb;
      nw.q2 = ZERO_ROB;
    end
  end

  always_comb begin
    ent_d = ent_q;
    iss_d = iss_q;
`ifdef RS_AGE_PRIORITY_EN
    age_d = age_q;
`endif
    if (rollback) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
      iss_d.ena = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
      age_d = '0;
`endif
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          if (cdb_hit(valid_arith_cdb, rob_id_arith_cdb, ent_q[i].q1)) begin
            ent_d[i].v1 = result_arith_cdb;
            ent_d[i].q1 = ZERO_ROB;
          end else if (cdb_hit(valid_ls_cdb, rob_id_ls_cdb, ent_q[i].q1)) begin
            ent_d[i].v1 = result_ls_cdb;
            ent_d[i].q1 = ZERO_ROB;
          end
          if (cdb_hit(valid_arith_cdb, rob_id_arith_cdb, ent_q[i].q2)) begin
            ent_d[i].v2 = result_arith_cdb;
            ent_d[i].q2 = ZERO_ROB;
          end else if (cdb_hit(valid_ls_cdb, rob_id_ls_cdb, ent_q[i].q2)) begin
            ent_d[i].v2 = result_ls_cdb;
            ent_d[i].q2 = ZERO_ROB;
          end
        end
      end
      iss_d.ena = sel_vld;
      if (sel_vld) begin
        iss_d.op  = ent_q[sel_idx].op;
        iss_d.v1  = ent_q[sel_idx].v1;
        iss_d.v2  = ent_q[sel_idx].v2;
        iss_d.pc  = ent_q[sel_idx].pc;
        iss_d.imm = ent_q[sel_idx].imm;
        iss_d.rob = ent_q[sel_idx].rob;
        ent_d[sel_idx].busy = 1'b0;
      end
      // Free slot is taken from pre-issue occupancy, never the issuing slot.
      if (ena_from_dsp && free_vld) begin
        ent_d[free_idx] = nw;
`ifdef RS_AGE_PRIORITY_EN
        age_d = age_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      iss_q <= ISS_RST;
`ifdef RS_AGE_PRIORITY_EN
      age_q <= '0;
`endif
    end else if (rdy) begin
      ent_q <= ent_d;
      iss_q <= iss_d;
`ifdef RS_AGE_PRIORITY_EN
      age_q <= age_d;
`endif
    end
  end

  assign full_to_if    = free_cnt < cnt_t'(2);
  assign ena_to_alu    = iss_q.ena;
  assign openum_to_alu = iss_q.op;
  assign V1_to_alu     = iss_q.v1;
  assign V2_to_alu     = iss_q.v2;
  assign pc_to_alu     = iss_q.pc;
  assign imm_to_alu    = iss_q.imm;
  assign rob_id_to_alu = iss_q.rob;
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Reservation station: the receiving end of the dispatcher's arithmetic/branch issue port.
- Buffers dispatched non-memory instructions and snoops both CDBs (arithmetic and load/store) to resolve operand tags.
- Issues one ready instruction per cycle to the arithmetic unit.
- Reports near-full back to the fetcher and flushes on rollback.

Parameters:
- RS_SIZE, 16, number of entries (power of two, >= 4).
- ROB_ID_W, 5, ROB tag width; tag 0 (ZERO_ROB) means "no dependency".
- DATA_W, 32, operand/immediate/pc width.
- OP_W, 6, openum width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low freezes all state and outputs
rollback  in  1  flush all entries
ena_from_dsp  in  1  dispatch valid (single-cycle pulse)
openum_from_dsp  in  OP_W  operation
V1_from_dsp, V2_from_dsp  in  DATA_W  operand values
Q1_from_dsp, Q2_from_dsp  in  ROB_ID_W  operand tags
pc_from_dsp  in  DATA_W  instruction pc
imm_from_dsp  in  DATA_W  immediate
rob_id_from_dsp  in  ROB_ID_W  destination ROB tag
valid_arith_cdb  in  1  arithmetic CDB valid
rob_id_arith_cdb  in  ROB_ID_W  arithmetic CDB tag
result_arith_cdb  in  DATA_W  arithmetic CDB value
valid_ls_cdb  in  1  load/store CDB valid
rob_id_ls_cdb  in  ROB_ID_W  load/store CDB tag
result_ls_cdb  in  DATA_W  load/store CDB value
full_to_if  out  1  stall fetch
ena_to_alu  out  1  issue valid pulse
openum_to_alu  out  OP_W  operation
V1_to_alu, V2_to_alu  out  DATA_W  resolved operands
pc_to_alu  out  DATA_W  pc
imm_to_alu  out  DATA_W  immediate
rob_id_to_alu  out  ROB_ID_W  destination tag

Behaviour:
- Reset: all entries invalid. ena_to_alu=0. openum_to_alu=OPENUM_NOP. All other ALU outputs 0. full_to_if=0.
- rdy low: no state change; outputs hold.
- Entry fields: busy, openum, V1, V2, Q1, Q2, pc, imm, rob_id.
- Entry is ready when busy and Q1==0 and Q2==0.
- Dispatch:
  - On ena_from_dsp, write into the lowest-index free entry, evaluated before this cycle's issue.
  - A slot freed by issue in the same cycle is not reused until the next cycle.
- Same-cycle forwarding on dispatch:
  - If an incoming Qn != 0 matches a valid CDB tag in the same cycle, store Vn = CDB result and Qn = 0.
  - Arithmetic CDB wins if both CDBs match.
- Wakeup: every cycle, each busy entry with Qn != 0 matching a valid CDB tag takes the CDB value and sets Qn = 0.
- CDB tag 0 never matches.
- Issue:
  - Each cycle, select one ready entry, using readiness registered at the previous edge.
  - Register its fields onto the ALU outputs, pulse ena_to_alu=1 for one cycle, and clear busy.
  - No ready entry: ena_to_alu=0 and the ALU outputs hold.
- Latency:
  - Dispatch with both operands ready at edge N -> ena_to_alu at edge N+1.
  - Operand woken by CDB at edge N -> issue at edge N+1.
- Bypass: CDB values are not bypassed straight to issue in the same cycle they arrive.
- full_to_if:
  - Combinational; 1 when free entries < 2.
  - This leaves room for the one instruction already in flight through the dispatcher's register stage.
- Dispatch while no entry is free: ignored; never overwrites a busy entry.
- Rollback:
  - Has priority over dispatch, wakeup and issue.
  - All busy bits clear and ena_to_alu=0 at the next edge.
  - A dispatch in the same cycle is dropped.
- Reset mid-operation behaves identically to rollback and also clears outputs.
- Throughput: one dispatch plus one issue per cycle; occupancy is unchanged in that case.

Optional Feature:
- Macro: RS_AGE_PRIORITY_EN.
- Defined:
  - Each entry stores a log2(RS_SIZE)+1-bit age stamp from a wrapping dispatch counter, reset to 0 on rst/rollback.
  - Issue selects the oldest ready entry, compared modulo wrap.
- Undefined: issue selects the lowest-index ready entry.
- Latency and interface are identical either way.

Decomposition:
- Shared constants header holds OPENUM_NOP, ZERO_ROB, ZERO_WORD and the type widths.
- rs_station reads these from that header and redefines none of them.
- One sub-module, rs_select: combinational priority encoder returning the lowest-index free slot, the selected ready slot, and the free count.
- rs_select is instantiated once.

Test Plan:
- Dispatch ADDI with rob_id=3, Q1=Q2=0, V1=5, imm=7 at edge 1 -> ena_to_alu=1 at edge 2 with rob_id_to_alu=3, V1_to_alu=5, imm_to_alu=7; then ena_to_alu=0.
- Dispatch ADD with Q1=4, V2=2; arithmetic CDB tag 4 value 10 two cycles later -> issue next edge with V1_to_alu=10, V2_to_alu=2.
- Dispatch with Q2=6 while the load/store CDB broadcasts tag 6 value 0xDEAD in the same cycle -> issued next edge with V2_to_alu=0xDEAD.
- Fill 15 entries that all wait on tag 9 -> full_to_if=1. Broadcast tag 9 -> one issue per cycle for 15 cycles. full_to_if drops once free count >= 2.
- 5 busy entries plus a dispatch in the same cycle as rollback=1 -> no ena_to_alu afterwards; free count = RS_SIZE.
- With RS_AGE_PRIORITY_EN: entries in slots 2 (older) and 0 (newer) both ready -> slot 2 issues first. Without the macro, slot 0 issues first.
